// File: rtl/npu_pkg.sv
// Shared types, default parameters and helpers for the convolve result writer.
package npu_pkg;
    localparam int DEF_IMG_W  = 28;
    localparam int DEF_K      = 3;
    localparam int DEF_STRIDE = 1;
    localparam int DEF_ACC_W  = 20;
    localparam int DEF_SHIFT  = 4;
    localparam int DEF_FIFO_D = 4;
    localparam int ADDR_W     = 10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } wr_state_t;

    function automatic int out_w(input int img_w, input int k, input int stride);
        return (img_w - k) / stride + 1;
    endfunction

    function automatic logic [7:0] sat_u8(input logic [31:0] p);
        return (p > 32'd255) ? 8'd255 : p[7:0];
    endfunction
endpackage

// File: rtl/npu_sync_fifo.sv
// Synchronous FIFO with registered read data, full/empty flags and a synchronous flush.
module npu_sync_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer bit tells full from empty when the indices match.
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            o_rdata <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                o_rdata <= r_mem[r_rptr[AW-1:0]];
                r_rptr  <= r_rptr + (AW+1)'(1);
            end
        end
    end
endmodule

// File: rtl/conv_result_writer.sv
// Buffers (sum1, sum2) result pairs, requantizes each sum to 8 bits and writes the
// pixels in raster order to the output feature-map memory, one pixel per cycle.
module conv_result_writer
    import npu_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int K      = DEF_K,
    parameter int STRIDE = DEF_STRIDE,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int SHIFT  = DEF_SHIFT,
    parameter int FIFO_D = DEF_FIFO_D
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_dst_start_addr,
    input  logic              i_res_valid,
    input  logic [ACC_W-1:0]  i_res_sum1,
    input  logic [ACC_W-1:0]  i_res_sum2,
    output logic              o_res_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic              o_busy,
    output logic              o_done
);
    localparam int              OUT_W = out_w(IMG_W, K, STRIDE);
    localparam int              RC_W  = $clog2(OUT_W);
    localparam logic [RC_W-1:0] LAST  = RC_W'(OUT_W - 1);

    wr_state_t          r_state;
    wr_state_t          w_state_nxt;
    logic [ADDR_W-1:0]  r_base;
    logic [ADDR_W-1:0]  r_cnt;
    logic [RC_W-1:0]    r_row;
    logic [RC_W-1:0]    r_col;
    logic               r_have;
    logic               r_sel;
    logic               r_fin;
    logic               r_last_q;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_flush;
    logic               w_fire;
    logic               w_pair_end;
    logic               w_last_px;
    logic [2*ACC_W-1:0] w_rdata;
    logic [ACC_W-1:0]   w_sum;

    npu_sync_fifo #(
        .WIDTH (2*ACC_W),
        .DEPTH (FIFO_D)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata ({i_res_sum2, i_res_sum1}),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_res_ready = (r_state == S_RUN) && !w_full && !r_fin;
    assign w_push      = i_res_valid && o_res_ready;
    assign w_fire      = (r_state == S_RUN) && r_have && !r_fin;
    // A pair ends after sum2, or after sum1 when sum1 already sits on the last column.
    assign w_pair_end  = w_fire && (r_sel || (r_col == LAST));
    assign w_last_px   = w_fire && (r_row == LAST) && (r_col == LAST);
    assign w_pop       = (r_state == S_RUN) && !r_fin && !w_empty && !w_last_px
                         && (!r_have || w_pair_end);
    assign w_flush     = (r_state == S_DONE);
    assign w_sum       = r_sel ? w_rdata[2*ACC_W-1:ACC_W] : w_rdata[ACC_W-1:0];
    assign o_busy      = (r_state == S_RUN);
    assign o_done      = (r_state == S_DONE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (r_last_q) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_cnt     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_have    <= 1'b0;
            r_sel     <= 1'b0;
            r_fin     <= 1'b0;
            r_last_q  <= 1'b0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_last_q <= w_last_px;
            o_wr_en  <= w_fire;
            if ((r_state == S_IDLE) && i_start) begin
                r_base <= i_dst_start_addr;
                r_cnt  <= '0;
                r_row  <= '0;
                r_col  <= '0;
                r_sel  <= 1'b0;
                r_have <= 1'b0;
                r_fin  <= 1'b0;
            end else if (r_state == S_DONE) begin
                r_have <= 1'b0;
            end else begin
                if (w_pop) begin
                    r_have <= 1'b1;
                end else if (w_pair_end) begin
                    r_have <= 1'b0;
                end
                if (w_last_px) begin
                    r_fin <= 1'b1;
                end
                if (w_fire) begin
                    // Pixel index equals row*OUT_W+col, so base+count gives the same 10-bit address.
                    o_wr_addr <= r_base + r_cnt;
                    o_wr_data <= sat_u8(32'(w_sum >> SHIFT));
                    r_cnt     <= r_cnt + ADDR_W'(1);
                    r_sel     <= !w_pair_end;
                    if (r_col == LAST) begin
                        r_col <= '0;
                        r_row <= r_row + RC_W'(1);
                    end else begin
                        r_col <= r_col + RC_W'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_result_writer.sv
// Self-checking bench: requant table, mid-frame reset, and randomized full frames
// (even and odd output widths) compared against a pixel-index reference model.
module tb_conv_result_writer;
    typedef struct {
        logic [19:0] sum1;
        logic [19:0] sum2;
        logic [7:0]  d1;
        logic [7:0]  d2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start    [2];
    logic [9:0]  base_in  [2];
    logic        valid    [2];
    logic [19:0] s1       [2];
    logic [19:0] s2       [2];
    logic        ready    [2];
    logic        wr_en    [2];
    logic [9:0]  wr_addr  [2];
    logic [7:0]  wr_data  [2];
    logic        busy     [2];
    logic        done     [2];

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [9:0]  got_addr [2][1024];
    logic [7:0]  got_data [2][1024];
    int          got_n    [2];
    int          first_wr_cyc [2];
    int          last_wr_cyc  [2];
    int          done_cnt [2];
    int          done_cyc [2];
    logic [19:0] p1 [1024];
    logic [19:0] p2 [1024];
    logic [9:0]  exp_addr [1024];
    logic [7:0]  exp_data [1024];
    int          exp_n;
    int          acc0_cyc;
    bit          stall_seen;
    int          acc_before_stall;
    vec_t        tbl [5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_result_writer #(.IMG_W(28)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_dst_start_addr(base_in[0]),
        .i_res_valid(valid[0]), .i_res_sum1(s1[0]), .i_res_sum2(s2[0]), .o_res_ready(ready[0]),
        .o_wr_en(wr_en[0]), .o_wr_addr(wr_addr[0]), .o_wr_data(wr_data[0]),
        .o_busy(busy[0]), .o_done(done[0])
    );

    conv_result_writer #(.IMG_W(27)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_dst_start_addr(base_in[1]),
        .i_res_valid(valid[1]), .i_res_sum1(s1[1]), .i_res_sum2(s2[1]), .o_res_ready(ready[1]),
        .o_wr_en(wr_en[1]), .o_wr_addr(wr_addr[1]), .o_wr_data(wr_data[1]),
        .o_busy(busy[1]), .o_done(done[1])
    );

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (wr_en[k] === 1'b1) begin
                if (got_n[k] < 1024) begin
                    got_addr[k][got_n[k]] = wr_addr[k];
                    got_data[k][got_n[k]] = wr_data[k];
                end
                got_n[k]++;
                last_wr_cyc[k] = cyc;
                if (first_wr_cyc[k] < 0) first_wr_cyc[k] = cyc;
            end
            if (done[k] === 1'b1) begin
                done_cnt[k]++;
                done_cyc[k] = cyc;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int s);
        int p = s / 16;
        return (p > 255) ? 255 : p;
    endfunction

    // Walk output pixel indices; sum2 is skipped when sum1 is the last pixel of a row.
    task automatic build_model(input int ow, input int base, input int npairs);
        int idx = 0;
        int total = ow * ow;
        exp_n = 0;
        for (int i = 0; i < npairs && idx < total; i++) begin
            int col = idx % ow;
            exp_addr[exp_n] = 10'((base + idx) % 1024);
            exp_data[exp_n] = 8'(sat(int'(p1[i])));
            exp_n++;
            idx++;
            if (idx < total && col != ow - 1) begin
                exp_addr[exp_n] = 10'((base + idx) % 1024);
                exp_data[exp_n] = 8'(sat(int'(p2[i])));
                exp_n++;
                idx++;
            end
        end
    endtask

    task automatic clear_mon(input int k);
        got_n[k] = 0;
        first_wr_cyc[k] = -1;
        last_wr_cyc[k] = -1;
        done_cnt[k] = 0;
        done_cyc[k] = -1;
    endtask

    task automatic pulse_start(input int k, input logic [9:0] b);
        start[k] = 1'b1;
        base_in[k] = b;
        @(posedge clk); #1;
        start[k] = 1'b0;
        base_in[k] = 10'($urandom);
    endtask

    task automatic send_pairs(input int k, input int n, input bit gaps);
        int guard;
        stall_seen = 0;
        acc_before_stall = -1;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            valid[k] = 1'b1;
            s1[k] = p1[i];
            s2[k] = p2[i];
            guard = 0;
            while (ready[k] !== 1'b1 && guard < 200) begin
                if (!stall_seen) begin
                    stall_seen = 1;
                    acc_before_stall = i;
                end
                @(posedge clk); #1;
                guard++;
            end
            if (guard >= 200) begin
                check("ready_timeout", 0, 1);
                valid[k] = 1'b0;
                return;
            end
            if (i == 0) acc0_cyc = cyc + 1;
            @(posedge clk); #1;
            valid[k] = 1'b0;
        end
    endtask

    task automatic run_frame(input int k, input int ow, input logic [9:0] base, input bit gaps);
        int npairs = ow * ((ow + 1) / 2);
        int g = 0;
        for (int i = 0; i < npairs; i++) begin
            p1[i] = $urandom_range(0, 1) ? 20'($urandom_range(0, 4095)) : 20'($urandom_range(0, 20'hFFFFF));
            p2[i] = $urandom_range(0, 1) ? 20'($urandom_range(0, 4095)) : 20'($urandom_range(0, 20'hFFFFF));
        end
        build_model(ow, int'(base), npairs);
        clear_mon(k);
        pulse_start(k, base);
        check("busy_after_start", longint'(busy[k]), 1);
        pulse_start(k, base ^ 10'h155);
        send_pairs(k, npairs, gaps);
        while (done_cnt[k] == 0 && g < 3000) begin @(negedge clk); g++; end
        check("frame_done_seen", longint'(done_cnt[k] > 0), 1);
        repeat (4) @(negedge clk);
        check("write_count", got_n[k], exp_n);
        for (int i = 0; i < exp_n && i < got_n[k]; i++) begin
            check($sformatf("wr_addr[%0d]", i), got_addr[k][i], exp_addr[i]);
            check($sformatf("wr_data[%0d]", i), got_data[k][i], exp_data[i]);
        end
        check("done_pulses", done_cnt[k], 1);
        check("done_after_last_write", done_cyc[k], last_wr_cyc[k] + 1);
        check("busy_after_done", longint'(busy[k]), 0);
        check("ready_after_done", longint'(ready[k]), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        tbl[0] = '{20'h00320, 20'h12345, 8'h32, 8'hFF};
        tbl[1] = '{20'h00000, 20'h0000F, 8'h00, 8'h00};
        tbl[2] = '{20'h00FF0, 20'h00FFF, 8'hFF, 8'hFF};
        tbl[3] = '{20'h00010, 20'h01000, 8'h01, 8'hFF};
        tbl[4] = '{20'h007F0, 20'hFFFFF, 8'h7F, 8'hFF};
        for (int k = 0; k < 2; k++) begin
            start[k] = 0; base_in[k] = '0; valid[k] = 0; s1[k] = '0; s2[k] = '0;
            clear_mon(k);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("rst_wr_en", longint'(wr_en[k]), 0);
            check("rst_wr_addr", longint'(wr_addr[k]), 0);
            check("rst_wr_data", longint'(wr_data[k]), 0);
            check("rst_busy", longint'(busy[k]), 0);
            check("rst_done", longint'(done[k]), 0);
            check("rst_ready", longint'(ready[k]), 0);
        end

        // Requant table at base 100, then reset mid-frame after 10 writes.
        for (int i = 0; i < 5; i++) begin
            p1[i] = tbl[i].sum1;
            p2[i] = tbl[i].sum2;
        end
        clear_mon(0);
        pulse_start(0, 10'd100);
        send_pairs(0, 5, 0);
        g = 0;
        while (got_n[0] < 10 && g < 100) begin @(negedge clk); g++; end
        check("table_writes", got_n[0], 10);
        check("first_write_latency", first_wr_cyc[0], acc0_cyc + 2);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("tbl_addr1[%0d]", i), got_addr[0][2*i], 100 + 2*i);
            check($sformatf("tbl_data1[%0d]", i), got_data[0][2*i], tbl[i].d1);
            check($sformatf("tbl_addr2[%0d]", i), got_addr[0][2*i+1], 101 + 2*i);
            check($sformatf("tbl_data2[%0d]", i), got_data[0][2*i+1], tbl[i].d2);
        end
        check("busy_mid_frame", longint'(busy[0]), 1);
        rst = 1'b1;
        #1;
        check("midrst_wr_addr", longint'(wr_addr[0]), 0);
        check("midrst_wr_data", longint'(wr_data[0]), 0);
        check("midrst_busy", longint'(busy[0]), 0);
        check("midrst_ready", longint'(ready[0]), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_no_done", done_cnt[0], 0);
        check("midrst_idle_busy", longint'(busy[0]), 0);

        // Full frame at base 1000: address wrap, stray start ignored, FIFO back-pressure.
        run_frame(0, 26, 10'd1000, 0);
        check("first_write_latency_frame", first_wr_cyc[0], acc0_cyc + 2);
        check("wrap_pixel24_addr", got_addr[0][24], 0);
        check("last_addr", got_addr[0][675], (1000 + 675) % 1024);
        check("ready_stalled", stall_seen, 1);
        check("accepted_before_stall_ge4", longint'(acc_before_stall >= 4), 1);

        run_frame(0, 26, 10'($urandom), 1);
        run_frame(1, 25, 10'($urandom), 0);
        run_frame(1, 25, 10'($urandom), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
